// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the system-ID slave (ID word at
// address 0, build timestamp at address 1), compares both words against the
// expected values and reports pass / fail / timeout.
//
// Handshake: avm_read/avm_address are driven purely from the FSM state, so they
// stay stable while avm_waitrequest=1. A read is accepted in any cycle where
// avm_read=1 and avm_waitrequest=0; avm_readdata is captured in that cycle.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5B23_715C,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned RETRY_MAX          = 2,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Timeout fires in the cycle that completes the TIMEOUT_CYCLES-th stall,
  // so avm_read is high for exactly TIMEOUT_CYCLES stalled cycles.
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_LAST = 4'(RETRY_MAX);

  state_t      state;
  state_t      next_state;
  logic [15:0] wait_cnt;
  logic [3:0]  attempt;
  logic        auto_pending;

  logic        launch;
  logic        accept;
  logic        abort;
  logic        in_read;
  logic        match;
  logic        retry;
  logic        give_up;

  assign in_read   = (state == RD_ID) || (state == RD_TS);
  assign match     = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
  assign fsm_state = state;

  // Moore outputs: derived only from state so a reset drops them at once.
  assign avm_read    = in_read;
  assign avm_address = (state == RD_TS);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    next_state = state;
    launch     = 1'b0;
    accept     = 1'b0;
    abort      = 1'b0;
    retry      = 1'b0;
    give_up    = 1'b0;
    case (state)
      IDLE: begin
        if (start || auto_pending) begin
          launch     = 1'b1;
          next_state = RD_ID;
        end
      end
      RD_ID, RD_TS: begin
        if (!avm_waitrequest) begin
          accept     = 1'b1;
          next_state = (state == RD_ID) ? RD_TS : CHECK;
        end else if (wait_cnt == WAIT_LAST) begin
          abort      = 1'b1;
          next_state = DONE;
        end
      end
      CHECK: begin
        if (match) begin
          next_state = DONE;
        end else if (attempt < RETRY_LAST) begin
          retry      = 1'b1;
          next_state = RD_ID;
        end else begin
          give_up    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Auto-start request: armed by reset, consumed by the first clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) auto_pending <= AUTO_START;
    else       auto_pending <= 1'b0;
  end

  // Consecutive-waitrequest counter, cleared on entry to each read state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 16'd0;
    end else if (!in_read || (next_state != state)) begin
      wait_cnt <= 16'd0;
    end else if (avm_waitrequest) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Retry counter: cleared at launch, bumped on each mismatch retry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       attempt <= 4'd0;
    else if (launch) attempt <= 4'd0;
    else if (retry)  attempt <= attempt + 4'd1;
  end

  // Captured read data, held until overwritten by the next accepted read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else if (accept) begin
      if (state == RD_ID) id_value <= avm_readdata;
      else                ts_value <= avm_readdata;
    end
  end

  // Result flags: cleared at launch, set by the outcome, held while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else if (launch) begin
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else if (abort) begin
      fail    <= 1'b1;
      timeout <= 1'b1;
    end else if (state == CHECK) begin
      if (match)   pass <= 1'b1;
      if (give_up) fail <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker. Two instances: dut_m (manual start) for
// most scenarios, dut_a (auto start) for the post-reset launch.
module tb_sysid_checker;

  logic clock = 1'b0;
  logic reset = 1'b1;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- manual-start instance ----------------
  logic        m_start;
  logic        m_addr, m_read, m_wait;
  logic [31:0] m_rdata;
  logic        m_busy, m_done, m_pass, m_fail, m_tmo;
  logic [31:0] m_id, m_ts;
  logic [2:0]  m_state;

  // slave model controls
  logic [31:0] ts_ret;
  int          stall_cfg;
  int          stall_left;
  logic        stuck, stuck_ts;

  assign m_rdata = m_addr ? ts_ret : 32'h0000_0000;
  assign m_wait  = m_read && (stuck || (stuck_ts && m_addr) || (stall_left != 0));

  // Slave stall model: stall_cfg wait cycles before each accepted read.
  always @(posedge clock or posedge reset) begin
    if (reset)                      stall_left <= stall_cfg;
    else if (!m_read)               stall_left <= stall_cfg;
    else if (m_wait) begin
      if (stall_left > 0)           stall_left <= stall_left - 1;
    end else                        stall_left <= stall_cfg;
  end

  sysid_checker #(
    .EXPECTED_ID(32'h0), .EXPECTED_TIMESTAMP(32'h5B23715C),
    .TIMEOUT_CYCLES(255), .RETRY_MAX(2), .AUTO_START(1'b0)
  ) dut_m (
    .clock(clock), .reset(reset), .start(m_start),
    .avm_address(m_addr), .avm_read(m_read), .avm_readdata(m_rdata),
    .avm_waitrequest(m_wait), .busy(m_busy), .done(m_done), .pass(m_pass),
    .fail(m_fail), .timeout(m_tmo), .id_value(m_id), .ts_value(m_ts),
    .fsm_state(m_state)
  );

  // ---------------- auto-start instance ----------------
  logic        a_start;
  logic        a_addr, a_read;
  logic [31:0] a_rdata;
  logic        a_busy, a_done, a_pass, a_fail, a_tmo;
  logic [31:0] a_id, a_ts;
  logic [2:0]  a_state;

  assign a_rdata = a_addr ? 32'h5B23715C : 32'h0000_0000;

  sysid_checker #(
    .EXPECTED_ID(32'h0), .EXPECTED_TIMESTAMP(32'h5B23715C),
    .TIMEOUT_CYCLES(255), .RETRY_MAX(2), .AUTO_START(1'b1)
  ) dut_a (
    .clock(clock), .reset(reset), .start(a_start),
    .avm_address(a_addr), .avm_read(a_read), .avm_readdata(a_rdata),
    .avm_waitrequest(1'b0), .busy(a_busy), .done(a_done), .pass(a_pass),
    .fail(a_fail), .timeout(a_tmo), .id_value(a_id), .ts_value(a_ts),
    .fsm_state(a_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Start is high during cycle 0; returns at the start of cycle 1.
  task automatic pulse_start();
    @(negedge clock);
    m_start = 1'b1;
    @(posedge clock);
    #1 m_start = 1'b0;
  endtask

  // Observation results of one sequence on dut_m (cycle 1 = first after start).
  int done_cyc, n_read, n_acc, n_done, first_rd, last_rd, n_busy, unstable, both_hi;

  task automatic observe(input int max_cyc);
    logic prev_stall;
    logic prev_addr;
    done_cyc = -1; n_read = 0; n_acc = 0; n_done = 0; first_rd = -1; last_rd = -1;
    n_busy = 0; unstable = 0; both_hi = 0;
    prev_stall = 1'b0; prev_addr = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clock);
      if (m_read) begin
        n_read++;
        if (first_rd < 0) first_rd = k;
        last_rd = k;
        if (!m_wait) n_acc++;
      end
      if (prev_stall && (!m_read || (m_addr != prev_addr))) unstable++;
      prev_stall = m_read && m_wait;
      prev_addr  = m_addr;
      if (m_busy) n_busy++;
      if (m_pass && m_fail) both_hi++;
      if (m_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
      end
      if ((done_cyc >= 0) && (k == done_cyc + 2)) break;
    end
    if (done_cyc < 0) check("done_within_budget", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int a_done_cnt, a_first_rd, a_done_cyc;

  initial begin
    m_start = 1'b0; a_start = 1'b0;
    ts_ret = 32'h5B23715C; stall_cfg = 0; stuck = 1'b0; stuck_ts = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_read",    {31'd0, m_read}, 32'd0);
    check("rst_busy",    {31'd0, m_busy}, 32'd0);
    check("rst_done",    {31'd0, m_done}, 32'd0);
    check("rst_pass",    {31'd0, m_pass}, 32'd0);
    check("rst_fail",    {31'd0, m_fail}, 32'd0);
    check("rst_timeout", {31'd0, m_tmo},  32'd0);
    check("rst_ts",      m_ts,            32'd0);
    check("rst_state",   {29'd0, m_state}, 32'd0);
    check("rst_a_busy",  {31'd0, a_busy}, 32'd0);
    reset = 1'b0;

    // Auto start: begins cycle 1 after release; start pulses while busy ignored
    a_done_cnt = 0; a_first_rd = -1; a_done_cyc = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (a_read && a_first_rd < 0) a_first_rd = k;
      if (a_done) begin
        a_done_cnt++;
        if (a_done_cyc < 0) a_done_cyc = k;
      end
      a_start = (k == 2) || (k == 4);
    end
    a_start = 1'b0;
    check("auto_first_read", a_first_rd, 32'd1);
    check("auto_done_cyc",   a_done_cyc, 32'd4);
    check("auto_done_count", a_done_cnt, 32'd1);
    check("auto_pass",       {31'd0, a_pass}, 32'd1);
    check("auto_fail",       {31'd0, a_fail}, 32'd0);
    check("auto_idle_after", {31'd0, a_busy}, 32'd0);
    check("manual_stays_idle", {31'd0, m_busy}, 32'd0);

    // Zero-wait pass
    pulse_start();
    observe(50);
    check("zw_first_read", first_rd, 32'd1);
    check("zw_last_read",  last_rd,  32'd2);
    check("zw_read_cycles", n_read,  32'd2);
    check("zw_done_cyc",   done_cyc, 32'd4);
    check("zw_busy_cycles", n_busy,  32'd4);
    check("zw_pass",    {31'd0, m_pass}, 32'd1);
    check("zw_fail",    {31'd0, m_fail}, 32'd0);
    check("zw_timeout", {31'd0, m_tmo},  32'd0);
    check("zw_id",      m_id, 32'h0000_0000);
    check("zw_ts",      m_ts, 32'h5B23715C);

    // Three waitrequest cycles per read
    stall_cfg = 3;
    @(negedge clock);
    pulse_start();
    observe(50);
    check("st_done_cyc",   done_cyc, 32'd10);
    check("st_read_cycles", n_read,  32'd8);
    check("st_accepts",    n_acc,    32'd2);
    check("st_stable",     unstable, 32'd0);
    check("st_pass",       {31'd0, m_pass}, 32'd1);
    check("st_ts",         m_ts, 32'h5B23715C);
    stall_cfg = 0;

    // Timestamp mismatch with two retries
    ts_ret = 32'h12345678;
    @(negedge clock);
    pulse_start();
    observe(50);
    check("mm_accepts",  n_acc,    32'd6);
    check("mm_done_cyc", done_cyc, 32'd10);
    check("mm_done_count", n_done, 32'd1);
    check("mm_pass",    {31'd0, m_pass}, 32'd0);
    check("mm_fail",    {31'd0, m_fail}, 32'd1);
    check("mm_timeout", {31'd0, m_tmo},  32'd0);
    check("mm_ts",      m_ts, 32'h12345678);
    check("mm_exclusive", both_hi, 32'd0);
    ts_ret = 32'h5B23715C;

    // waitrequest stuck high: timeout after 255 stalls, no retry
    stuck = 1'b1;
    @(negedge clock);
    pulse_start();
    observe(400);
    check("to_read_cycles", n_read,  32'd255);
    check("to_done_cyc",   done_cyc, 32'd256);
    check("to_done_count", n_done,   32'd1);
    check("to_accepts",    n_acc,    32'd0);
    check("to_timeout", {31'd0, m_tmo},  32'd1);
    check("to_fail",    {31'd0, m_fail}, 32'd1);
    check("to_pass",    {31'd0, m_pass}, 32'd0);
    stuck = 1'b0;

    // Reset while stalled in RD_TS
    stuck_ts = 1'b1;
    @(negedge clock);
    pulse_start();
    repeat (4) @(negedge clock);
    check("rs_pre_read", {31'd0, m_read}, 32'd1);
    check("rs_pre_addr", {31'd0, m_addr}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rs_read",    {31'd0, m_read}, 32'd0);
    check("rs_busy",    {31'd0, m_busy}, 32'd0);
    check("rs_timeout", {31'd0, m_tmo},  32'd0);
    check("rs_fail",    {31'd0, m_fail}, 32'd0);
    check("rs_ts",      m_ts, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    stuck_ts = 1'b0;
    repeat (5) @(negedge clock);
    check("rs_idle_busy",  {31'd0, m_busy}, 32'd0);
    check("rs_idle_state", {29'd0, m_state}, 32'd0);
    pulse_start();
    observe(50);
    check("rs_restart_done", done_cyc, 32'd4);
    check("rs_restart_pass", {31'd0, m_pass}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM master that sits directly downstream of the system-ID slave.
- After reset, or on request, it reads the ID word (address 0) and the build timestamp (address 1) and compares both against expected values.
- It reports pass, fail or timeout to the game controller and LEDs, so that a board running stale or mismatched hardware is flagged before the snake logic starts.

Parameters:
- EXPECTED_ID, 0, value the slave must return at address 0.
- EXPECTED_TIMESTAMP, 1529049436 (0x5B23715C), value the slave must return at address 1.
- TIMEOUT_CYCLES, 255, maximum consecutive waitrequest cycles per read before abort (1..65535).
- RETRY_MAX, 2, extra full read sequences attempted after a mismatch (0..15).
- AUTO_START, 1, when 1 a check sequence launches automatically on the first clock after reset release.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to run a check; ignored while busy
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  Avalon read strobe
- avm_readdata  in  32  slave read data, valid in the cycle avm_read=1 and avm_waitrequest=0
- avm_waitrequest  in  1  slave stall; tie 0 for a zero-wait slave
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at completion
- pass  out  1  level: last sequence matched both words
- fail  out  1  level: last sequence ended in mismatch or timeout
- timeout  out  1  level: last sequence aborted on waitrequest timeout
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured timestamp word

Behaviour:
- Reset (asynchronous): every output is 0, state is IDLE, attempt counter is 0, wait counter is 0. A reset mid-transaction drops avm_read immediately, with no handshake completion.
- States and transitions:
  - IDLE: go to RD_ID on start, or on the first post-reset cycle if AUTO_START=1.
  - RD_ID: go to RD_TS on accept.
  - RD_TS: go to CHECK on accept.
  - CHECK: go to RD_ID (retry) or DONE.
  - DONE: one cycle, then IDLE.
- Entry to RD_ID from IDLE: clear pass/fail/timeout, clear attempt counter, assert busy.
- RD_ID: avm_read=1, avm_address=0.
- RD_TS: avm_read=1, avm_address=1.
- Avalon hold rule: avm_address and avm_read stay stable while avm_waitrequest=1.
- Accept: a read is accepted in a cycle with avm_read=1 and avm_waitrequest=0.
  - avm_readdata is registered into id_value or ts_value in that cycle.
  - avm_read deasserts after an accepted TS read.
  - RD_ID to RD_TS is back-to-back, with read held high.
- Wait counter (16 bit):
  - Clears on entry to each read state.
  - Increments every cycle avm_waitrequest=1.
  - When it equals TIMEOUT_CYCLES while waitrequest is still 1: drop avm_read next cycle, set timeout=1 and fail=1, go to DONE with no retry.
- CHECK (1 cycle): match = (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TIMESTAMP), full 32-bit equality.
  - Match: pass=1, go to DONE.
  - Mismatch and attempt<RETRY_MAX: attempt+1, go to RD_ID.
  - Mismatch and attempt==RETRY_MAX: fail=1, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 from the following cycle. pass/fail/timeout/id_value/ts_value hold until the next sequence starts.
- Latency with a zero-wait slave, start at cycle 0:
  - avm_read high cycles 1–2 (address 0 then 1)
  - CHECK at cycle 3
  - done pulse at cycle 4
  - busy high cycles 1–4
- Simultaneous events:
  - start while busy (including the DONE cycle) is ignored.
  - start in IDLE on the cycle after DONE launches a new sequence.
  - pass and fail are never both 1.

Test Plan:
- Zero-wait slave returning 0 and 0x5B23715C, start at cycle 0 -> avm_read cycles 1–2, done pulse at cycle 4, pass=1, fail=0, id_value=0, ts_value=0x5B23715C.
- waitrequest held 3 cycles on each read -> same results; address/read stable during stalls, done at cycle 10.
- Slave timestamp 0x12345678, RETRY_MAX=2 -> three full read sequences (6 accepted reads), then fail=1, pass=0, timeout=0, ts_value=0x12345678.
- waitrequest stuck high, TIMEOUT_CYCLES=255 -> avm_read drops after 255 stall cycles, timeout=1, fail=1, single done pulse, no retry.
- AUTO_START=1, no start pulse -> sequence begins on the first cycle after reset release and ends pass=1; start pulses injected while busy change nothing.
- Reset asserted while stalled in RD_TS -> avm_read=0 and all outputs 0 immediately; after release with AUTO_START=0, remains IDLE until start.
